am2940_dma_multi: RTL



---
 rtl/am2940_dma_multi.sv | 121 ++++++++++++
 1 files changed

// File: rtl/am2940_dma_multi.sv
// am2940_dma_multi: multi-channel Am2940-style DMA address generator with round-robin arbitration.
// Ports:
//   TRANS     clock, all state updates on the rising edge
//   res       asynchronous active-low reset
//   cfg_*     channel configuration write (sel 0 addr, 1 word reg/count, 2 control, 3 ignored)
//   ch_req    per-channel level transfer requests
//   mem_ack   memory acknowledge that completes the current transfer
//   A/A_valid address of the granted channel while a transfer is in progress
//   grant     one-hot granted channel
//   ch_done   sticky per-channel termination flags, DONE is their OR
//   busy      arbiter is not idle
module am2940_dma_multi #(
   parameter int WIDTH = 8,
   parameter int NCH = 4,
   localparam int CW = $clog2(NCH)
) (
   input  logic             TRANS,
   input  logic             res,
   input  logic             cfg_we,
   input  logic [CW-1:0]    cfg_ch,
   input  logic [1:0]       cfg_sel,
   input  logic [WIDTH-1:0] cfg_data,
   input  logic [NCH-1:0]   ch_req,
   input  logic             mem_ack,
   output logic [WIDTH-1:0] A,
   output logic             A_valid,
   output logic [NCH-1:0]   grant,
   output logic [NCH-1:0]   ch_done,
   output logic             DONE,
   output logic             busy
);
   typedef enum logic {IDLE, XFER} state_t;
   state_t state_q, state_d;
   logic [WIDTH-1:0] addr_q [NCH], addr_d [NCH];
   logic [WIDTH-1:0] wreg_q [NCH], wreg_d [NCH];
   logic [WIDTH-1:0] wcnt_q [NCH], wcnt_d [NCH];
   logic [3:0]       ctrl_q [NCH], ctrl_d [NCH];
   logic [NCH-1:0]   done_q, done_d, elig;
   logic [CW-1:0]    rr_q, rr_d, gnt_q, gnt_d, idx, pick;
   logic             found, term;
   logic [1:0]       mode;
   logic [WIDTH-1:0] nadr, nwcnt;
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wreg_d  = wreg_q;
      wcnt_d  = wcnt_q;
      ctrl_d  = ctrl_q;
      done_d  = done_q;
      rr_d    = rr_q;
      gnt_d   = gnt_q;
      found   = 1'b0;
      pick    = rr_q;
      idx     = rr_q;
      for (int c = 0; c < NCH; c++) elig[c] = ch_req[c] & ctrl_q[c][3] & ~done_q[c];
      // search starts just after the last winner; k = NCH wraps back onto rr itself
      for (int k = 1; k <= NCH; k++) begin
         idx = rr_q + CW'(k);
         if (!found && elig[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
      mode  = ctrl_q[gnt_q][1:0];
      nadr  = ctrl_q[gnt_q][2] ? addr_q[gnt_q] - 1'b1 : addr_q[gnt_q] + 1'b1;
      nwcnt = mode == 2'd1 ? wcnt_q[gnt_q] + 1'b1 : mode == 2'd2 ? wcnt_q[gnt_q] : wcnt_q[gnt_q] - 1'b1;
      term  = mode == 2'd0 ? nwcnt == '0 :
              mode == 2'd1 ? nwcnt == wreg_q[gnt_q] :
              mode == 2'd2 ? nadr == wreg_q[gnt_q] : 1'b0;
      if (state_q == IDLE && found) begin
         state_d = XFER;
         gnt_d   = pick;
         rr_d    = pick;
      end
      if (state_q == XFER && mem_ack) begin
         addr_d[gnt_q] = nadr;
         wcnt_d[gnt_q] = nwcnt;
         done_d[gnt_q] = done_q[gnt_q] | term;
         state_d       = IDLE;
      end
      // configuration is applied last so it overrides a same-edge transfer update
      if (cfg_we) begin
         if (cfg_sel == 2'd0) addr_d[cfg_ch] = cfg_data;
         if (cfg_sel == 2'd1) begin
            wreg_d[cfg_ch] = cfg_data;
            wcnt_d[cfg_ch] = ctrl_q[cfg_ch][1:0] == 2'd1 ? '0 : cfg_data;
         end
         if (cfg_sel == 2'd2) ctrl_d[cfg_ch] = cfg_data[3:0];
         done_d[cfg_ch] = 1'b0;
      end
   end
   always_ff @(posedge TRANS or negedge res) begin
      if (!res) begin
         state_q <= IDLE;
         for (int c = 0; c < NCH; c++) begin
            addr_q[c] <= '0;
            wreg_q[c] <= '0;
            wcnt_q[c] <= '0;
            ctrl_q[c] <= '0;
         end
         done_q <= '0;
         rr_q   <= CW'(NCH - 1);
         gnt_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wreg_q  <= wreg_d;
         wcnt_q  <= wcnt_d;
         ctrl_q  <= ctrl_d;
         done_q  <= done_d;
         rr_q    <= rr_d;
         gnt_q   <= gnt_d;
      end
   end
   assign A_valid = state_q == XFER;
   assign busy    = state_q != IDLE;
   assign A       = A_valid ? addr_q[gnt_q] : '0;
   assign grant   = A_valid ? {{(NCH - 1){1'b0}}, 1'b1} << gnt_q : '0;
   assign ch_done = done_q;
   assign DONE    = |done_q;
endmodule
